// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolve path: branch types, FSM states,
// and the fetch increment.
package branch_pkg;

  typedef enum logic [1:0] {
    BT_NONE = 2'b00,
    BT_BEQ  = 2'b01,
    BT_BNE  = 2'b10,
    BT_BLE  = 2'b11
  } branch_type_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_EVAL   = 2'b01,
    S_UPDATE = 2'b10
  } state_t;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/response bundle between the control FSM (master) and the
// branch resolve unit (slave).
interface branch_resolve_unit_if
  import branch_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int CNT_W     = 16
);
  logic                 pc_inc;
  logic                 start;
  branch_type_t         branch_type;
  logic [WORD_SIZE-1:0] reg_a;
  logic [WORD_SIZE-1:0] reg_b;
  logic [WORD_SIZE-1:0] offset;
  logic [WORD_SIZE-1:0] pc;
  logic                 busy;
  logic                 done;
  logic                 taken;
  logic [CNT_W-1:0]     taken_count;

  modport master (
    output pc_inc, start, branch_type, reg_a, reg_b, offset,
    input  pc, busy, done, taken, taken_count
  );

  modport slave (
    input  pc_inc, start, branch_type, reg_a, reg_b, offset,
    output pc, busy, done, taken, taken_count
  );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition: (type, a, b) -> cond. BLE is unsigned.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  branch_type_t         branch_type,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  output logic                 cond
);

  // Select the comparison named by the branch type; BT_NONE never branches.
  always_comb begin
    cond = 1'b0;
    case (branch_type)
      BT_BEQ:  cond = (a == b);
      BT_BNE:  cond = (a != b);
      BT_BLE:  cond = (a <= b);
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Owns the program counter: PC+4 on fetch, and a three-step
// capture / evaluate / update sequence for conditional branches.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int                   WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
  parameter int                   CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_resolve_unit_if.slave  bus
);

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q;
  logic                 busy_q, done_q, taken_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [WORD_SIZE-1:0] a_p0, b_p0, off_p0;
  branch_type_t         bt_p0;
  logic                 cond_c;
  logic                 cond_p1;
  logic                 accept;

  // A request is only taken in IDLE; start/pc_inc while busy are dropped.
  assign accept = (state_q == S_IDLE) && bus.start;

  branch_cond_eval #(.WORD_SIZE(WORD_SIZE)) u_cond (
    .branch_type (bt_p0),
    .a           (a_p0),
    .b           (b_p0),
    .cond        (cond_c)
  );

  // Next-state logic for the IDLE -> EVAL -> UPDATE -> IDLE sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_EVAL;
      S_EVAL:   state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Stage p0: operands are frozen at the start edge; stage p1: registered condition.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0   <= bus.reg_a;
      b_p0   <= bus.reg_b;
      off_p0 <= bus.offset;
      bt_p0  <= bus.branch_type;
    end
    if (state_q == S_EVAL) cond_p1 <= cond_c;
  end

  // Control state, PC and counter; reset discards any request in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start)       busy_q <= 1'b1;
          else if (bus.pc_inc) pc_q   <= pc_q + WORD_SIZE'(PC_STEP);
        end
        S_UPDATE: begin
          if (cond_p1) begin
            pc_q  <= pc_q + (off_p0 << 2);
            cnt_q <= cnt_q + CNT_W'(1);
          end
          taken_q <= cond_p1;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.taken       = taken_q;
  assign bus.taken_count = cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  localparam int WS = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.WORD_SIZE(WS), .CNT_W(CW)) bus ();

  branch_resolve_unit #(.WORD_SIZE(WS), .RESET_PC(32'h0), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request at the current (negedge) point, then scramble operands
  // after the start edge so late changes would show up as wrong results.
  task automatic issue(input branch_type_t bt, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] off, input logic inc);
    bus.start       = 1'b1;
    bus.branch_type = bt;
    bus.reg_a       = a;
    bus.reg_b       = b;
    bus.offset      = off;
    bus.pc_inc      = inc;
    @(posedge clk);
    #1;
    bus.start       = 1'b0;
    bus.branch_type = BT_NONE;
    bus.reg_a       = 32'hDEAD_BEEF;
    bus.reg_b       = 32'h1234_5678;
    bus.offset      = 32'h7777_0000;
  endtask

  // Two busy cycles with PC untouched, then the done cycle with results.
  task automatic wait_done(input string tag, input logic [31:0] pc_prev, input logic [31:0] exp_pc,
                           input logic exp_taken, input logic [15:0] exp_cnt);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check({tag, "_busy"}, bus.busy, 1'b1);
      check({tag, "_nodone"}, bus.done, 1'b0);
      check({tag, "_pchold"}, bus.pc, pc_prev);
    end
    @(negedge clk);
    check({tag, "_done"}, bus.done, 1'b1);
    check({tag, "_busy0"}, bus.busy, 1'b0);
    check({tag, "_pc"}, bus.pc, exp_pc);
    check({tag, "_taken"}, bus.taken, exp_taken);
    check({tag, "_cnt"}, bus.taken_count, exp_cnt);
  endtask

  initial begin
    reset           = 1'b1;
    bus.pc_inc      = 1'b0;
    bus.start       = 1'b0;
    bus.branch_type = BT_NONE;
    bus.reg_a       = '0;
    bus.reg_b       = '0;
    bus.offset      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pc", bus.pc, 32'h0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_taken", bus.taken, 1'b0);
    check("rst_cnt", bus.taken_count, 16'h0);
    reset = 1'b0;

    // Three fetch increments
    bus.pc_inc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("inc_nodone", bus.done, 1'b0);
    end
    bus.pc_inc = 1'b0;
    check("inc_pc", bus.pc, 32'h0000_000C);
    check("inc_busy", bus.busy, 1'b0);

    // Walk PC up to 0x100
    bus.pc_inc = 1'b1;
    repeat (61) @(negedge clk);
    bus.pc_inc = 1'b0;
    check("inc_pc100", bus.pc, 32'h0000_0100);

    // BEQ taken, forward offset
    issue(BT_BEQ, 32'h55, 32'h55, 32'h3, 1'b0);
    wait_done("beq", 32'h100, 32'h10C, 1'b1, 16'd1);

    // BEQ taken, negative offset back to 0x100 (back-to-back)
    issue(BT_BEQ, 32'h9, 32'h9, 32'hFFFF_FFFD, 1'b0);
    wait_done("beqneg", 32'h10C, 32'h100, 1'b1, 16'd2);

    // BNE not taken
    issue(BT_BNE, 32'h7, 32'h7, 32'h5, 1'b0);
    wait_done("bne", 32'h100, 32'h100, 1'b0, 16'd2);
    @(negedge clk);
    check("bne_pulse1", bus.done, 1'b0);
    check("bne_taken_hold", bus.taken, 1'b0);

    // Reset to get PC=0, then BLE unsigned with wrap
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst2_pc", bus.pc, 32'h0);
    check("rst2_cnt", bus.taken_count, 16'h0);
    issue(BT_BLE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done("ble", 32'h0, 32'hFFFF_FFFC, 1'b1, 16'd1);

    // start+pc_inc together, pc_inc held while busy, second start in done cycle
    issue(BT_BEQ, 32'h1, 32'h1, 32'h1, 1'b1);
    wait_done("combo1", 32'hFFFF_FFFC, 32'h0, 1'b1, 16'd2);
    bus.pc_inc = 1'b0;
    issue(BT_BNE, 32'h1, 32'h2, 32'h2, 1'b0);
    wait_done("combo2", 32'h0, 32'h8, 1'b1, 16'd3);

    // Reset during EVAL of a taken BEQ
    issue(BT_BEQ, 32'h4, 32'h4, 32'h4, 1'b0);
    @(negedge clk);
    check("rev_busy", bus.busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rev_pc", bus.pc, 32'h0);
    check("rev_busy0", bus.busy, 1'b0);
    check("rev_done", bus.done, 1'b0);
    check("rev_cnt", bus.taken_count, 16'h0);
    check("rev_taken", bus.taken, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rev_nodone", bus.done, 1'b0);
      check("rev_pchold", bus.pc, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
